// File: rtl/tdm_demux_1x16_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x16_pkg
//   Shared definitions for the 16-channel TDM link: default channel count,
//   slot index width and the receive-side alignment state encoding. The
//   transmit-side mux imports the same package so both ends agree.
// ---------------------------------------------------------------------------
package tdm_demux_1x16_pkg;

  localparam int NCH_DEF = 16;  // channels (slots) per frame, power of 2
  localparam int SW_DEF  = 4;   // slot index width, log2(NCH_DEF)

  // Alignment state; the state bit itself is the lock indication.
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_1x16_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
//   SW-bit slot index counter for the TDM receiver.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (count -> 0)
//     en     advance to the next slot (natural modulo-2^SW wrap)
//     load   jump to slot 1 (slot 0 was just taken on a sync)
//     clear  force slot 0
//     count  current slot index
//     wrap   high while count is the last slot of the frame
//   Priority: clear > load > en.
// ---------------------------------------------------------------------------
module tdm_slot_counter #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic          clear,
  output logic [SW-1:0] count,
  output logic          wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= SW'(1);
    end else if (en) begin
      count <= count + SW'(1);
    end
  end

  assign wrap = (count == {SW{1'b1}});

endmodule

// File: rtl/tdm_demux_1x16.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x16
//   Receive end of the 16-channel serial TDM link. Samples one bit per
//   enabled cycle into a slot shadow register, aligns to the slot-0 sync
//   marker and presents each completed frame in parallel.
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     din         serial data bit (valid when en=1)
//     en          sample strobe
//     sync        frame marker, high with en on the slot-0 sample
//     sel         slot index the next enabled sample goes to
//     dout        last complete frame, bit k = slot k
//     frame_valid 1-cycle pulse when dout updates
//     lock        high while aligned
//     sync_err    1-cycle pulse on early or missing sync
// ---------------------------------------------------------------------------
module tdm_demux_1x16
  import tdm_demux_1x16_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int SW          = SW_DEF,
  parameter int STRICT_SYNC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  input  logic           en,
  input  logic           sync,
  output logic [SW-1:0]  sel,
  output logic [NCH-1:0] dout,
  output logic           frame_valid,
  output logic           lock,
  output logic           sync_err
);

  state_t         state_reg;
  // Only slots 0..NCH-2 need storage: the last slot's bit is taken straight
  // from din when the frame is assembled into dout.
  logic [NCH-2:0] shadow_reg;

  logic locked;
  logic sync_early;    // sync seen away from slot 0 (includes last slot)
  logic sync_missing;  // slot 0 reached without sync
  logic take_first;    // enabled sample that starts a frame at slot 0
  logic take_slot;     // enabled in-frame sample at slot sel
  logic cnt_clear;
  logic wrap;

  always_comb begin
    locked       = (state_reg == ST_LOCKED);
    sync_early   = locked && sync && (sel != '0);
    sync_missing = locked && !sync && (sel == '0) && (STRICT_SYNC != 0);
    take_first   = en && sync && (!locked || sync_early);
    take_slot    = en && locked && !sync_early && !sync_missing;
    cnt_clear    = en && sync_missing;
  end

  tdm_slot_counter #(
    .SW(SW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (take_slot),
    .load  (take_first),
    .clear (cnt_clear),
    .count (sel),
    .wrap  (wrap)
  );

  // One flop per stored slot; a realigning sync rewrites slot 0 directly.
  genvar gi;
  generate
    for (gi = 0; gi < NCH - 1; gi++) begin : g_shadow
      logic wr_bit;
      assign wr_bit = (take_first && (gi == 0)) || (take_slot && (sel == SW'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= 1'b0;
        end else if (wr_bit) begin
          shadow_reg[gi] <= din;
        end
      end
    end
  endgenerate

  // Alignment FSM plus the frame output and pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_UNLOCKED;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        case (state_reg)
          ST_UNLOCKED: begin
            if (sync) state_reg <= ST_LOCKED;
          end
          ST_LOCKED: begin
            if (sync_early) begin
              sync_err <= 1'b1;
            end else if (sync_missing) begin
              sync_err  <= 1'b1;
              state_reg <= ST_UNLOCKED;
            end else if (wrap) begin
              dout        <= {din, shadow_reg};
              frame_valid <= 1'b1;
            end
          end
          default: state_reg <= ST_UNLOCKED;
        endcase
      end
    end
  end

  assign lock = state_reg;

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x16
//   Directed bench for the TDM receiver: a table of whole frames plus
//   hand-written sequences for reset, early sync, sync on the last slot and
//   missing sync.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x16;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic        en;
  logic        sync;
  logic [3:0]  sel;
  logic [15:0] dout;
  logic        frame_valid;
  logic        lock;
  logic        sync_err;

  int n_cmp;
  int n_err;

  tdm_demux_1x16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .sel         (sel),
    .dout        (dout),
    .frame_valid (frame_valid),
    .lock        (lock),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pat;
    bit          gap;
    logic [15:0] exp_dout;
  } frame_vec_t;

  frame_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic tick(input logic e, input logic s, input logic d);
    @(negedge clk);
    en   = e;
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  // Send slots first..last of pat while locked; sync accompanies slot 0.
  // If the range ends at slot 15 a frame_valid pulse with dout=pat follows.
  task automatic send_slots(input logic [15:0] pat, input int first, input int last,
                            input bit gap);
    for (int i = first; i <= last; i++) begin
      if (gap) begin
        tick(1'b0, 1'b0, ~pat[i]);
        chk("gap_sel_hold", 32'(sel), 32'(i));
        chk("gap_fv_low", 32'(frame_valid), 32'd0);
      end
      chk("sel_before_sample", 32'(sel), 32'(i));
      tick(1'b1, (i == 0), pat[i]);
      chk("frame_valid", 32'(frame_valid), 32'((i == 15) ? 1 : 0));
      chk("sync_err_quiet", 32'(sync_err), 32'd0);
      chk("lock_high", 32'(lock), 32'd1);
      if (i == 15) chk("dout_frame", 32'(dout), 32'(pat));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    din   = 1'b0;

    vecs[0] = '{pat: 16'hA5C3, gap: 1'b0, exp_dout: 16'hA5C3};
    vecs[1] = '{pat: 16'h5A3C, gap: 1'b1, exp_dout: 16'h5A3C};
    vecs[2] = '{pat: 16'hA5C3, gap: 1'b1, exp_dout: 16'hA5C3};
    vecs[3] = '{pat: 16'h0001, gap: 1'b0, exp_dout: 16'h0001};
    vecs[4] = '{pat: 16'h8000, gap: 1'b0, exp_dout: 16'h8000};
    vecs[5] = '{pat: 16'hFFFF, gap: 1'b0, exp_dout: 16'hFFFF};

    // ---- power-up reset ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // ---- reset mid-frame ----
    send_slots(16'h1357, 0, 15, 1'b0);
    send_slots(16'h00FF, 0, 4, 1'b0);
    chk("pre_rst_sel", 32'(sel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_lock", 32'(lock), 32'd0);
    chk("async_rst_fv", 32'(frame_valid), 32'd0);
    chk("async_rst_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset mid-frame checked");

    // 16 enabled samples without sync: stay unlocked, nothing captured.
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, i[0]);
      chk("nosync_lock", 32'(lock), 32'd0);
      chk("nosync_fv", 32'(frame_valid), 32'd0);
      chk("nosync_sel", 32'(sel), 32'd0);
    end
    chk("nosync_dout", 32'(dout), 32'd0);
    $display("16 samples without sync: stayed unlocked");

    // ---- table of frames (aligned, gapped, back-to-back) ----
    for (int v = 0; v < 6; v++) begin
      send_slots(vecs[v].pat, 0, 15, vecs[v].gap);
      chk("vec_dout", 32'(dout), 32'(vecs[v].exp_dout));
      $display("frame %0d: pat=%h gap=%0d dout=%h", v, vecs[v].pat, vecs[v].gap, dout);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("fv_drops_on_idle", 32'(frame_valid), 32'd0);

    // ---- early sync at sel=7, then realigned frame 16'hBEEF ----
    send_slots(16'h0000, 0, 6, 1'b0);
    chk("early_pre_sel", 32'(sel), 32'd7);
    tick(1'b1, 1'b1, 1'b1);  // slot 0 of BEEF (bit0 = 1)
    chk("early_err", 32'(sync_err), 32'd1);
    chk("early_sel", 32'(sel), 32'd1);
    chk("early_dout_hold", 32'(dout), 32'hFFFF);
    chk("early_fv", 32'(frame_valid), 32'd0);
    chk("early_lock", 32'(lock), 32'd1);
    send_slots(16'hBEEF, 1, 15, 1'b0);
    $display("early sync realign: dout=%h", dout);

    // ---- sync coinciding with slot 15: early sync, no frame ----
    send_slots(16'h1111, 0, 14, 1'b0);
    chk("last_pre_sel", 32'(sel), 32'd15);
    tick(1'b1, 1'b1, 1'b0);  // slot 0 of 16'h6A52 (bit0 = 0)
    chk("last_err", 32'(sync_err), 32'd1);
    chk("last_fv", 32'(frame_valid), 32'd0);
    chk("last_dout_hold", 32'(dout), 32'hBEEF);
    chk("last_sel", 32'(sel), 32'd1);
    send_slots(16'h6A52, 1, 15, 1'b0);
    $display("sync on slot 15 treated as early: dout=%h", dout);

    // ---- missing sync at slot 0 of the next frame ----
    send_slots(16'h0F0F, 0, 15, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("miss_err", 32'(sync_err), 32'd1);
    chk("miss_lock", 32'(lock), 32'd0);
    chk("miss_fv", 32'(frame_valid), 32'd0);
    chk("miss_sel", 32'(sel), 32'd0);
    chk("miss_dout_hold", 32'(dout), 32'h0F0F);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      chk("miss_stay_unlocked", 32'(lock), 32'd0);
      chk("miss_err_pulse", 32'(sync_err), 32'd0);
      chk("miss_sel_zero", 32'(sel), 32'd0);
    end
    $display("missing sync dropped lock");
    send_slots(16'hC001, 0, 15, 1'b0);
    $display("relocked: dout=%h", dout);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
